mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Consumes the EX/MEM pipeline register outputs (MEM* signals).
- Performs data-memory loads and stores over a req/ack bus that can insert wait states. Stalls upstream while an access is outstanding.
- Selects write-back data and registers it into the MEM/WB register that feeds the register file.

Parameters:
- TIMEOUT, 16: max cycles in REQ without dmem_ack before the access is aborted as a bus error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- MEMrd  in  5  destination register
- MEMPC  in  32  instruction PC
- MEMALUOut  in  32  ALU result / memory address
- MEMDatabus3  in  32  store data
- MEMRegWrite  in  1  register-file write enable
- MEMMemRead  in  1  load
- MEMMemWrite  in  1  store
- MEMMemtoReg  in  2  write-back select
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  bus completion
- dmem_rdata  in  32  load data, valid with dmem_ack
- mem_stall  out  1  upstream PC, IF/ID, ID/EX and EX/MEM registers hold while 1
- WBrd  out  5  registered destination
- WBRegWrite  out  1  registered write enable
- WBData  out  32  registered write-back data
- WBPC  out  32  registered PC, for exception reporting
- exc_misalign  out  1  one-cycle pulse
- exc_bus  out  1  one-cycle pulse

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, and every output is 0. This includes dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, WB*, exc_*. Reset mid-access drops dmem_req immediately and discards the access.
- Access = MEMMemRead | MEMMemWrite. If both are set, the access is treated as a read.
- Write-back data sel:
  - 00: ALUOut
  - 01: load data
  - 10: MEMPC+4 (32-bit wrap, so FFFFFFFC+4 gives 0)
  - 11: ALUOut
- States: IDLE, REQ, RESP.
- IDLE, no access:
  - mem_stall=0.
  - At the edge, WB regs load rd, RegWrite, sel data, PC.
  - Latency is 1 cycle.
- IDLE, access, MEMALUOut[1:0]!=0 (misaligned):
  - No bus request.
  - At the edge, WB loads a bubble (WBRegWrite=0, WBPC=MEMPC) and exc_misalign pulses 1 cycle.
  - mem_stall=0; stay IDLE.
- IDLE, access, aligned:
  - mem_stall=1.
  - Latch addr, wdata and we into the dmem_* registers. counter=0. WB loads a bubble. Next state is REQ.
- REQ:
  - dmem_req=1 and mem_stall=1. dmem_addr, dmem_wdata and dmem_we are held stable.
  - WB loads a bubble each cycle.
  - If dmem_ack=1: capture dmem_rdata into rdata_q and go to RESP.
  - Else if counter==TIMEOUT-1: set rdata_q=0, flag bus error, go to RESP.
  - Else counter+1.
  - When ack and timeout coincide, ack wins.
- RESP:
  - dmem_req=0, mem_stall=0.
  - At the edge, WB loads rd, RegWrite and sel data (rdata_q for sel 01), then the state returns to IDLE.
  - On a bus error, WBRegWrite=0 and exc_bus pulses with that WB load.
  - Upstream advances on this same edge, so the next instruction is seen in IDLE and the access is never re-issued.
- Minimum access cost is 2 stall cycles (IDLE+REQ) with an immediate ack. Each ack wait cycle adds 1.
- A dmem_ack outside REQ is ignored.
- Stores write back nothing unless MEMRegWrite=1. Stores never see rdata.

Decomposition:
- Shared package mem_pkg:
  - MemtoReg encodings (MTR_ALU=0, MTR_MEM=1, MTR_PC4=2)
  - FSM state encodings (S_IDLE, S_REQ, S_RESP)
  - TIMEOUT default
- Sub-module dmem_access_fsm: states, timeout counter, bus registers, rdata_q, bus-error flag.
- mem_wb_stage wraps it with the alignment check, data mux and MEM/WB register.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs 0. Release, then ALU instr rd=5, ALUOut=0x1234, sel=00, RegWrite=1 → next edge WBrd=5, WBData=0x1234, WBRegWrite=1, mem_stall never 1.
- Load: addr=0x40; memory model acks 3 cycles after req with rdata=0xDEADBEEF → dmem_req high 4 cycles, mem_stall high 5 cycles, then WBData=0xDEADBEEF, WBRegWrite=1. Exactly one WB write.
- Store: addr=0x80, wdata=0xCAFEF00D → dmem_we=1 with addr/wdata stable through REQ, WBRegWrite=0. Next instruction is issued with no repeated request.
- Misaligned: load at 0x42 → no dmem_req, exc_misalign 1 cycle, WBRegWrite=0, mem_stall=0.
- Timeout: never ack, TIMEOUT=16 → dmem_req high exactly 16 cycles, exc_bus pulses, WBRegWrite=0. Also, ack on the 16th cycle → normal completion with no exc_bus.
- Reset mid-REQ plus JAL: assert reset during the 2nd REQ cycle → dmem_req=0 immediately and state IDLE after release. JAL with MEMPC=0xFFFFFFFC, sel=10 → WBData=0x00000000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access / write-back stage.
// Write-back select, access FSM states and bus timeout default.
package mem_pkg;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [31:0] wb_sel(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] ld,
    input logic [31:0] pc
  );
    logic [31:0] r;
    r = alu;
    unique case (sel)
      MTR_MEM: r = ld;
      MTR_PC4: r = pc + 32'd4;
      default: r = alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus between the MEM stage and memory.
// The stage is master; memory answers with ack and rdata.
interface mem_wb_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/dmem_access_fsm.sv
// Bus sequencer: IDLE -> REQ (wait for ack or timeout) -> RESP.
// Owns the bus registers, load-data capture and bus-error flag.
module dmem_access_fsm
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  start_we,
  input  logic [31:0]           start_addr,
  input  logic [31:0]           start_wdata,
  mem_wb_stage_if.master        dmem,
  output state_t                state,
  output logic [31:0]           rdata_q,
  output logic                  bus_err
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      rdata_q         <= '0;
      bus_err         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_REQ;
            cnt             <= '0;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= start_we;
            dmem.dmem_addr  <= start_addr;
            dmem.dmem_wdata <= start_wdata;
            bus_err         <= 1'b0;
          end
        end
        S_REQ: begin
          if (dmem.dmem_ack) begin
            // stores never expose read data
            rdata_q       <= dmem.dmem_we ? '0 : dmem.dmem_rdata;
            bus_err       <= 1'b0;
            dmem.dmem_req <= 1'b0;
            state         <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rdata_q       <= '0;
            bus_err       <= 1'b1;
            dmem.dmem_req <= 1'b0;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          bus_err <= 1'b0;
        end
        default: begin
          state         <= S_IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: alignment check, data-memory access, write-back select
// and the MEM/WB pipeline register.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4:0]     MEMrd,
  input  logic [31:0]    MEMPC,
  input  logic [31:0]    MEMALUOut,
  input  logic [31:0]    MEMDatabus3,
  input  logic           MEMRegWrite,
  input  logic           MEMMemRead,
  input  logic           MEMMemWrite,
  input  logic [1:0]     MEMMemtoReg,
  mem_wb_stage_if.master dmem,
  output logic           mem_stall,
  output logic [4:0]     WBrd,
  output logic           WBRegWrite,
  output logic [31:0]    WBData,
  output logic [31:0]    WBPC,
  output logic           exc_misalign,
  output logic           exc_bus
);

  logic        access;
  logic        aligned;
  logic        pass;
  logic        mis;
  logic        go;
  state_t      state;
  logic [31:0] rdata_q;
  logic        bus_err;
  logic [31:0] sel_data;

  assign access   = MEMMemRead | MEMMemWrite;
  assign aligned  = MEMALUOut[1:0] == 2'b00;
  assign pass     = ~access;
  assign mis      = access & ~aligned;
  assign go       = access & aligned;
  assign sel_data = wb_sel(MEMMemtoReg, MEMALUOut, rdata_q, MEMPC);

  // held low through reset so upstream never freezes on garbage
  assign mem_stall = reset &
    ((state == S_IDLE & go) | state == S_REQ);

  dmem_access_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (go),
    .start_we    (MEMMemWrite & ~MEMMemRead),
    .start_addr  (MEMALUOut),
    .start_wdata (MEMDatabus3),
    .dmem        (dmem),
    .state       (state),
    .rdata_q     (rdata_q),
    .bus_err     (bus_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WBrd         <= '0;
      WBRegWrite   <= 1'b0;
      WBData       <= '0;
      WBPC         <= '0;
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
    end else begin
      exc_misalign <= 1'b0;
      exc_bus      <= 1'b0;
      WBPC         <= MEMPC;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            pass: begin
              WBrd       <= MEMrd;
              WBRegWrite <= MEMRegWrite;
              WBData     <= sel_data;
            end
            mis: begin
              WBrd         <= '0;
              WBRegWrite   <= 1'b0;
              WBData       <= '0;
              exc_misalign <= 1'b1;
            end
            go: begin
              WBrd       <= '0;
              WBRegWrite <= 1'b0;
              WBData     <= '0;
            end
          endcase
        end
        S_RESP: begin
          WBrd       <= MEMrd;
          WBRegWrite <= MEMRegWrite & ~bus_err;
          WBData     <= sel_data;
          exc_bus    <= bus_err;
        end
        default: begin
          WBrd       <= '0;
          WBRegWrite <= 1'b0;
          WBData     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: scenario tasks plus randomized traffic
// checked against an instruction-level timing/data model.
module tb_mem_wb_stage;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic [4:0]  MEMrd;
  logic [31:0] MEMPC;
  logic [31:0] MEMALUOut;
  logic [31:0] MEMDatabus3;
  logic        MEMRegWrite;
  logic        MEMMemRead;
  logic        MEMMemWrite;
  logic [1:0]  MEMMemtoReg;
  logic        mem_stall;
  logic [4:0]  WBrd;
  logic        WBRegWrite;
  logic [31:0] WBData;
  logic [31:0] WBPC;
  logic        exc_misalign;
  logic        exc_bus;

  int          vectors;
  int          errors;
  int          resp_delay;
  logic [31:0] resp_data;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .MEMrd        (MEMrd),
    .MEMPC        (MEMPC),
    .MEMALUOut    (MEMALUOut),
    .MEMDatabus3  (MEMDatabus3),
    .MEMRegWrite  (MEMRegWrite),
    .MEMMemRead   (MEMMemRead),
    .MEMMemWrite  (MEMMemWrite),
    .MEMMemtoReg  (MEMMemtoReg),
    .dmem         (bus),
    .mem_stall    (mem_stall),
    .WBrd         (WBrd),
    .WBRegWrite   (WBRegWrite),
    .WBData       (WBData),
    .WBPC         (WBPC),
    .exc_misalign (exc_misalign),
    .exc_bus      (exc_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory responder: ack after resp_delay REQ cycles, noise otherwise
  initial begin
    int rcnt;
    rcnt = 0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req === 1'b1) begin
        bus.dmem_ack   = (resp_delay >= 0) && (rcnt == resp_delay);
        bus.dmem_rdata = bus.dmem_ack ? resp_data : $urandom;
        rcnt++;
      end else begin
        rcnt           = 0;
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
    end
  end

  task automatic drive_idle();
    MEMrd       = 5'd0;
    MEMPC       = 32'h0;
    MEMALUOut   = 32'h0;
    MEMDatabus3 = 32'h0;
    MEMRegWrite = 1'b0;
    MEMMemRead  = 1'b0;
    MEMMemWrite = 1'b0;
    MEMMemtoReg = 2'd0;
  endtask

  // Apply one instruction; starts and ends just after a rising edge.
  task automatic issue(
    input string       nm,
    input logic [4:0]  rd,
    input logic [31:0] pc,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input logic        rw,
    input logic        mr,
    input logic        mw,
    input logic [1:0]  sel,
    input int          delay,
    input logic [31:0] rdat
  );
    logic        acc, mis, berr, e_rw;
    logic [31:0] ld, e_data;
    int          n_req, e_stall, stalls, reqs, cyc;
    acc = mr | mw;
    mis = acc && (alu[1:0] != 2'b00);
    if (!acc || mis) begin
      n_req = 0; e_stall = 0; berr = 1'b0;
    end else begin
      berr    = !(delay >= 0 && delay < TIMEOUT);
      n_req   = berr ? TIMEOUT : delay + 1;
      e_stall = n_req + 1;
    end
    ld     = (acc && !mis && mr && !berr) ? rdat : 32'h0;
    e_data = (sel == 2'd1) ? ld : (sel == 2'd2) ? pc + 32'd4 : alu;
    e_rw   = rw && !mis && !berr;
    resp_delay  = delay;
    resp_data   = rdat;
    MEMrd       = rd;
    MEMPC       = pc;
    MEMALUOut   = alu;
    MEMDatabus3 = sd;
    MEMRegWrite = rw;
    MEMMemRead  = mr;
    MEMMemWrite = mw;
    MEMMemtoReg = sel;
    stalls = 0; reqs = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req === 1'b1) begin
        reqs++;
        vectors++;
        if (bus.dmem_addr !== alu || bus.dmem_wdata !== sd ||
            bus.dmem_we !== (mw & ~mr)) begin
          errors++;
          $display("FAIL %s bus: addr=%h wd=%h we=%b want %h %h %b",
            nm, bus.dmem_addr, bus.dmem_wdata, bus.dmem_we,
            alu, sd, mw & ~mr);
        end
      end
      if (mem_stall !== 1'b1) break;
      stalls++;
      @(posedge clk); #1;
      vectors++;
      if (WBRegWrite !== 1'b0 || exc_bus !== 1'b0 ||
          exc_misalign !== 1'b0) begin
        errors++;
        $display("FAIL %s bubble: rw=%b eb=%b em=%b want 0 0 0",
          nm, WBRegWrite, exc_bus, exc_misalign);
      end
      cyc++;
      if (cyc > 64) begin
        errors++;
        $display("FAIL %s stall_bound: got >64 stall cycles want %0d",
          nm, e_stall);
        break;
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (stalls != e_stall || reqs != n_req) begin
      errors++;
      $display("FAIL %s timing: stall=%0d req=%0d want %0d %0d",
        nm, stalls, reqs, e_stall, n_req);
    end
    vectors++;
    if (WBRegWrite !== e_rw || WBPC !== pc ||
        exc_misalign !== mis || exc_bus !== berr) begin
      errors++;
      $display("FAIL %s wb_ctl: rw=%b pc=%h em=%b eb=%b want %b %h %b %b",
        nm, WBRegWrite, WBPC, exc_misalign, exc_bus,
        e_rw, pc, mis, berr);
    end
    if (!mis && !(sel == 2'd1 && !acc)) begin
      vectors++;
      if (WBrd !== rd || WBData !== e_data) begin
        errors++;
        $display("FAIL %s wb_data: rd=%0d data=%h want %0d %h",
          nm, WBrd, WBData, rd, e_data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    resp_delay = 0;
    resp_data  = '0;
    for (int i = 0; i < 4; i++) begin
      MEMrd       = 5'($urandom);
      MEMPC       = $urandom;
      MEMALUOut   = $urandom & 32'hFFFF_FFFC;
      MEMDatabus3 = $urandom;
      MEMRegWrite = 1'($urandom);
      MEMMemRead  = 1'b1;
      MEMMemWrite = 1'($urandom);
      MEMMemtoReg = 2'($urandom);
      @(negedge clk);
      vectors++;
      if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata,
           mem_stall, WBrd, WBRegWrite, WBData, WBPC,
           exc_misalign, exc_bus} !== '0) begin
        errors++;
        $display("FAIL reset_outs: req=%b stall=%b wb=%h/%h want all 0",
          bus.dmem_req, mem_stall, WBData, WBPC);
      end
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_alu();
    issue("alu", 5'd5, 32'h100, 32'h1234, 32'h0,
          1'b1, 1'b0, 1'b0, 2'd0, 0, 32'h0);
  endtask

  task automatic test_load();
    issue("load", 5'd7, 32'h104, 32'h40, 32'h5555,
          1'b1, 1'b1, 1'b0, 2'd1, 3, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    issue("store", 5'd9, 32'h108, 32'h80, 32'hCAFEF00D,
          1'b0, 1'b0, 1'b1, 2'd0, 2, 32'h1111);
    issue("after_store", 5'd3, 32'h10C, 32'h77, 32'h0,
          1'b1, 1'b0, 1'b0, 2'd0, 0, 32'h0);
  endtask

  task automatic test_misaligned();
    issue("misalign", 5'd4, 32'h110, 32'h42, 32'h0,
          1'b1, 1'b1, 1'b0, 2'd1, 0, 32'h2222);
    issue("post_mis", 5'd6, 32'h114, 32'hABC, 32'h0,
          1'b1, 1'b0, 1'b0, 2'd3, 0, 32'h0);
  endtask

  task automatic test_timeout();
    issue("timeout", 5'd8, 32'h118, 32'h200, 32'h0,
          1'b1, 1'b1, 1'b0, 2'd1, -1, 32'h0);
    issue("ack_16th", 5'd8, 32'h11C, 32'h204, 32'h0,
          1'b1, 1'b1, 1'b0, 2'd1, 15, 32'h600DF00D);
    issue("both_rd", 5'd2, 32'h120, 32'h208, 32'h99,
          1'b1, 1'b1, 1'b1, 2'd1, 1, 32'h13579BDF);
  endtask

  task automatic test_reset_mid_req();
    resp_delay  = -1;
    MEMrd       = 5'd10;
    MEMPC       = 32'h200;
    MEMALUOut   = 32'h300;
    MEMDatabus3 = 32'h0;
    MEMRegWrite = 1'b1;
    MEMMemRead  = 1'b1;
    MEMMemWrite = 1'b0;
    MEMMemtoReg = 2'd1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    vectors++;
    if (bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_pre: req=%b want 1", bus.dmem_req);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0 ||
        WBRegWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_req_rst: req=%b stall=%b rw=%b want 0 0 0",
        bus.dmem_req, mem_stall, WBRegWrite);
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_jal();
    issue("jal_wrap", 5'd1, 32'hFFFF_FFFC, 32'h5, 32'h0,
          1'b1, 1'b0, 1'b0, 2'd2, 0, 32'h0);
    issue("load_after_rst", 5'd11, 32'h204, 32'h44, 32'h0,
          1'b1, 1'b1, 1'b0, 2'd1, 0, 32'h0BADCAFE);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int          r, d;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      d = (r < 6) ? r : (r == 6) ? 15 : (r == 7) ? -1
          : $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue("rand", 5'($urandom), $urandom & 32'hFFFF_FFFC, a,
            $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), d, $urandom);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    drive_idle();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_jal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, errors);
    $finish;
  end

endmodule
